// File: rtl/debug_word_select.sv
// Selects one of four 32-bit debug words for the seven-segment display feeder; debounced button stepping.
// Define DEBUG_WORD_SELECT_AUTOSCROLL_EN to build the timed auto-scroll prescaler.
module debug_word_select #(
    parameter logic [15:0] DEBOUNCE = 16'd50000,
    parameter logic [31:0] PRESCALE = 32'd50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_next,
    input  logic        auto_scroll,
    input  logic        hold,
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic [31:0] alu_result,
    input  logic [31:0] reg_data,
    output logic [1:0]  sel,
    output logic [31:0] seq,
    output logic        adv
);

    logic        sync1;
    logic        sync2;
    logic        btn_db;
    logic        btn_db_prev;
    logic [15:0] db_cnt;
    logic        man_adv;
    logic        tick;
    logic        adv_event;
    logic [31:0] word_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            btn_db      <= 1'b0;
            btn_db_prev <= 1'b0;
            db_cnt      <= '0;
        end else begin
            sync1       <= btn_next;
            sync2       <= sync1;
            btn_db_prev <= btn_db;
            // A level change is accepted only after DEBOUNCE consecutive differing samples.
            if (sync2 == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DEBOUNCE - 16'd1) begin
                btn_db <= sync2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 16'd1;
            end
        end
    end

    assign man_adv = btn_db & ~btn_db_prev;

`ifdef DEBUG_WORD_SELECT_AUTOSCROLL_EN
    logic [31:0] presc;

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
        end else if (!auto_scroll) begin
            presc <= '0;
        end else if (hold) begin
            presc <= presc;
        end else if (man_adv || (presc == PRESCALE - 32'd1)) begin
            // A manual press restarts the scroll period.
            presc <= '0;
        end else begin
            presc <= presc + 32'd1;
        end
    end

    assign tick = auto_scroll & ~hold & (presc == PRESCALE - 32'd1);
`else
    logic unused_auto_scroll;
    assign unused_auto_scroll = auto_scroll;
    assign tick               = 1'b0;
`endif

    // Press and tick on the same cycle merge into one advance; hold discards both.
    assign adv_event = (man_adv | tick) & ~hold;

    always_comb begin
        word_sel = pc;
        case (sel)
            2'd0:    word_sel = pc;
            2'd1:    word_sel = instr;
            2'd2:    word_sel = alu_result;
            default: word_sel = reg_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel <= 2'd0;
            seq <= '0;
            adv <= 1'b0;
        end else begin
            adv <= adv_event;
            if (adv_event) begin
                sel <= sel + 2'd1;
            end
            if (!hold) begin
                seq <= word_sel;
            end
        end
    end

endmodule
